// File: rtl/cmd_response_receiver.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48/136-bit frame MSB first,
// then reports framing and CRC7 status, or no_response if the card never answers.
module cmd_response_receiver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable_stp,
  input  logic         long_response,
  input  logic         check_crc,
  input  logic         cmd_in,
  output logic [135:0] pad_response,
  output logic         reception_complete,
  output logic         no_response,
  output logic         crc_error,
  output logic         frame_error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    CHECK,
    DONE,
    TIMEOUT
  } state_t;

  state_t             state_q, state_d;
  logic               long_q, long_d;
  logic               crc_en_q, crc_en_d;
  logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]         crc_q, crc_d;
  logic [135:0]       shift_q, shift_d;
  logic [135:0]       pad_q, pad_d;
  logic               rc_q, rc_d;
  logic               nr_q, nr_d;
  logic               crc_err_q, crc_err_d;
  logic               frame_err_q, frame_err_d;

  logic [CNT_W-1:0]   last_bit;
  logic [CNT_W-1:0]   crc_lo;
  logic [CNT_W-1:0]   crc_hi;
  logic               timeout_hit;
  logic               crc_fb;
  logic [6:0]         crc_upd;

  // bit_cnt k samples frame bit L-1-k; these bound the CRC-covered window in sample terms
  assign last_bit    = long_q ? CNT_W'(135) : CNT_W'(47);
  assign crc_lo      = long_q ? CNT_W'(8)   : CNT_W'(0);
  assign crc_hi      = long_q ? CNT_W'(127) : CNT_W'(39);
  assign timeout_hit = (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign crc_fb      = crc_q[6] ^ cmd_in;
  assign crc_upd     = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      long_q        <= 1'b0;
      crc_en_q      <= 1'b0;
      timeout_cnt_q <= '0;
      bit_cnt_q     <= '0;
      crc_q         <= '0;
      shift_q       <= '0;
      pad_q         <= '0;
      rc_q          <= 1'b0;
      nr_q          <= 1'b0;
      crc_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      long_q        <= long_d;
      crc_en_q      <= crc_en_d;
      timeout_cnt_q <= timeout_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      crc_q         <= crc_d;
      shift_q       <= shift_d;
      pad_q         <= pad_d;
      rc_q          <= rc_d;
      nr_q          <= nr_d;
      crc_err_q     <= crc_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (enable_stp) state_d = WAIT_START;
      WAIT_START: begin
        if (!enable_stp)      state_d = IDLE;
        else if (!cmd_in)     state_d = RECEIVE;
        else if (timeout_hit) state_d = TIMEOUT;
      end
      RECEIVE: begin
        if (!enable_stp)                state_d = IDLE;
        else if (bit_cnt_q == last_bit) state_d = CHECK;
      end
      CHECK:      state_d = enable_stp ? DONE : IDLE;
      DONE,
      TIMEOUT:    if (!enable_stp) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    long_d        = long_q;
    crc_en_d      = crc_en_q;
    timeout_cnt_d = timeout_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    crc_d         = crc_q;
    shift_d       = shift_q;
    pad_d         = pad_q;
    rc_d          = rc_q;
    nr_d          = nr_q;
    crc_err_d     = crc_err_q;
    frame_err_d   = frame_err_q;
    case (state_q)
      IDLE: begin
        timeout_cnt_d = '0;
        bit_cnt_d     = '0;
        crc_d         = '0;
        if (enable_stp) begin
          long_d   = long_response;
          crc_en_d = check_crc;
        end
      end
      WAIT_START: begin
        // the short-frame start bit is CRC-covered but is 0 into a zero register, so it is skipped
        if (enable_stp) begin
          if (!cmd_in) begin
            bit_cnt_d = CNT_W'(1);
            shift_d   = '0;
          end else begin
            timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
            if (timeout_hit) nr_d = 1'b1;
          end
        end
      end
      RECEIVE: begin
        if (enable_stp) begin
          shift_d   = {shift_q[134:0], cmd_in};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q >= crc_lo && bit_cnt_q <= crc_hi) crc_d = crc_upd;
        end
      end
      CHECK: begin
        if (enable_stp) begin
          pad_d       = long_q ? shift_q : {88'd0, shift_q[47:0]};
          rc_d        = 1'b1;
          frame_err_d = (long_q ? shift_q[134] : shift_q[46]) | ~shift_q[0];
          crc_err_d   = crc_en_q & (crc_q != shift_q[7:1]);
        end
      end
      DONE,
      TIMEOUT: begin
        if (!enable_stp) begin
          rc_d        = 1'b0;
          nr_d        = 1'b0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign pad_response       = pad_q;
  assign reception_complete = rc_q;
  assign no_response        = nr_q;
  assign crc_error          = crc_err_q;
  assign frame_error        = frame_err_q;

endmodule

// File: tb/tb_cmd_response_receiver.sv
// Bench for cmd_response_receiver: directed vector table, abort/reset sequences and random frames
// checked against a polynomial-division CRC7 reference model.
module tb_cmd_response_receiver;
  localparam int TO = 64;
  localparam logic [135:0] F1    = 136'h0800_0001_AA13;
  localparam logic [135:0] F1B20 = 136'h0800_0011_AA13;
  localparam logic [135:0] F1E0  = 136'h0800_0001_AA12;
  localparam logic [135:0] F1T   = 136'h4800_0001_AA13;

  logic         sd_clock;
  logic         reset;
  logic         enable_stp;
  logic         long_response;
  logic         check_crc;
  logic         cmd_in;
  logic [135:0] pad_response;
  logic         reception_complete;
  logic         no_response;
  logic         crc_error;
  logic         frame_error;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_txn = 0;
  logic [135:0] last_pad;
  logic [135:0] f1v;

  typedef struct {
    string        name;
    bit           lng;
    bit           chk;
    int           idle;
    logic [135:0] frame;
    logic [135:0] exp_pad;
    bit           exp_rc;
    bit           exp_nr;
    bit           exp_ce;
    bit           exp_fe;
  } vec_t;

  vec_t vecs[10];

  cmd_response_receiver #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .sd_clock          (sd_clock),
    .reset             (reset),
    .enable_stp        (enable_stp),
    .long_response     (long_response),
    .check_crc         (check_crc),
    .cmd_in            (cmd_in),
    .pad_response      (pad_response),
    .reception_complete(reception_complete),
    .no_response       (no_response),
    .crc_error         (crc_error),
    .frame_error       (frame_error)
  );

  initial sd_clock = 1'b0;
  always #5 sd_clock = ~sd_clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time budget exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7_ref(input logic [135:0] f, input bit lng);
    bit         q[$];
    logic [7:0] gen = 8'h89;
    logic [6:0] r;
    int         hi = lng ? 127 : 47;
    for (int i = hi; i >= 8; i--) q.push_back(f[i]);
    repeat (7) q.push_back(1'b0);
    for (int i = 0; i + 7 < q.size(); i++)
      if (q[i]) for (int j = 0; j < 8; j++) q[i+j] = q[i+j] ^ gen[7-j];
    for (int j = 0; j < 7; j++) r[6-j] = q[q.size()-7+j];
    return r;
  endfunction

  function automatic logic [135:0] build_frame(input bit lng, input logic [135:0] rnd);
    logic [135:0] f = '0;
    if (lng) begin
      f[133:128] = 6'h3F;
      f[127:8]   = rnd[127:8];
    end else begin
      f[45:8] = rnd[45:8];
    end
    f[7:1] = crc7_ref(f, lng);
    f[0]   = 1'b1;
    return f;
  endfunction

  function automatic vec_t mk(input string nm, input bit lng, input bit chk_en, input int idle,
                              input logic [135:0] frame, input logic [135:0] exp_pad,
                              input bit rc, input bit nr, input bit ce, input bit fe);
    vec_t v;
    v.name = nm; v.lng = lng; v.chk = chk_en; v.idle = idle; v.frame = frame;
    v.exp_pad = exp_pad; v.exp_rc = rc; v.exp_nr = nr; v.exp_ce = ce; v.exp_fe = fe;
    return v;
  endfunction

  task automatic do_txn(input vec_t v);
    int L;
    enable_stp    = 1'b1;
    long_response = v.lng;
    check_crc     = v.chk;
    cmd_in        = 1'b1;
    tick();
    // mode inputs must be latched on entry, later changes are ignored
    long_response = 1'($urandom);
    check_crc     = 1'($urandom);
    if (v.idle >= TO) begin
      for (int i = 0; i < TO; i++) begin
        cmd_in = 1'b1;
        tick();
        if (i == TO - 2) chk({v.name, ".nr_early"}, no_response, 0);
      end
    end else begin
      for (int i = 0; i < v.idle; i++) begin
        cmd_in = 1'b1;
        tick();
      end
      L = v.lng ? 136 : 48;
      for (int b = L - 1; b >= 0; b--) begin
        cmd_in = v.frame[b];
        tick();
      end
      chk({v.name, ".rc_early"}, reception_complete, 0);
      cmd_in = 1'($urandom);
      tick();
    end
    chk({v.name, ".pad"}, pad_response, v.exp_pad);
    chk({v.name, ".rc"},  reception_complete, v.exp_rc);
    chk({v.name, ".nr"},  no_response, v.exp_nr);
    chk({v.name, ".ce"},  crc_error, v.exp_ce);
    chk({v.name, ".fe"},  frame_error, v.exp_fe);
    chk({v.name, ".excl"}, reception_complete & no_response, 0);
    $display("txn %0d %s long=%0d chk=%0d idle=%0d pad=%h rc=%0d nr=%0d ce=%0d fe=%0d",
             n_txn, v.name, v.lng, v.chk, v.idle, pad_response, reception_complete,
             no_response, crc_error, frame_error);
    n_txn++;
    repeat (2) begin
      cmd_in = 1'($urandom);
      tick();
    end
    chk({v.name, ".hold_rc"},  reception_complete, v.exp_rc);
    chk({v.name, ".hold_nr"},  no_response, v.exp_nr);
    chk({v.name, ".hold_pad"}, pad_response, v.exp_pad);
    enable_stp = 1'b0;
    tick();
    chk({v.name, ".clr_flags"},
        {reception_complete, no_response, crc_error, frame_error}, 0);
    chk({v.name, ".keep_pad"}, pad_response, v.exp_pad);
    last_pad = v.exp_pad;
  endtask

  initial begin
    logic [135:0] r2, r2b, rnd, fr;
    vec_t         v;
    bit           lng, ce;
    int           idle, L, sel, pos;

    r2     = build_frame(1'b1, 136'h0123456789ABCDEF_FEDCBA9876543210_5A);
    r2b    = r2 ^ 136'h2;
    vecs[0] = mk("short_good",   0, 1, 5,  F1,    F1,    1, 0, 0, 0);
    vecs[1] = mk("short_bit20",  0, 1, 5,  F1B20, F1B20, 1, 0, 1, 0);
    vecs[2] = mk("short_end0",   0, 1, 3,  F1E0,  F1E0,  1, 0, 0, 1);
    vecs[3] = mk("short_trans1", 0, 1, 2,  F1T,   F1T,   1, 0, 1, 1);
    vecs[4] = mk("short_nocrc",  0, 0, 4,  F1B20, F1B20, 1, 0, 0, 0);
    vecs[5] = mk("r2_good",      1, 1, 3,  r2,    r2,    1, 0, 0, 0);
    vecs[6] = mk("r2_nocrc_bad", 1, 0, 1,  r2b,   r2b,   1, 0, 0, 0);
    vecs[7] = mk("r2_crc_bad",   1, 1, 0,  r2b,   r2b,   1, 0, 1, 0);
    vecs[8] = mk("start_at_64",  0, 1, 63, F1,    F1,    1, 0, 0, 0);
    vecs[9] = mk("timeout",      0, 1, 64, F1,    F1,    0, 1, 0, 0);

    reset = 1'b0; enable_stp = 1'b0; long_response = 1'b0; check_crc = 1'b0; cmd_in = 1'b1;
    repeat (3) tick();
    chk("reset.pad", pad_response, 0);
    chk("reset.flags", {reception_complete, no_response, crc_error, frame_error}, 0);
    reset = 1'b1;
    tick();
    last_pad = '0;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // abort mid-frame: drop enable after 20 frame samples
    f1v = F1;
    enable_stp = 1'b1; long_response = 1'b0; check_crc = 1'b1; cmd_in = 1'b1;
    tick(); tick();
    for (int b = 47; b >= 28; b--) begin
      cmd_in = f1v[b];
      tick();
    end
    enable_stp = 1'b0; cmd_in = 1'b0;
    tick();
    chk("abort.flags", {reception_complete, no_response, crc_error, frame_error}, 0);
    chk("abort.pad", pad_response, last_pad);
    for (int i = 0; i < TO + 4; i++) begin
      cmd_in = 1'($urandom);
      tick();
    end
    chk("abort.idle_flags", {reception_complete, no_response, crc_error, frame_error}, 0);
    $display("txn %0d abort pad=%h rc=%0d nr=%0d", n_txn, pad_response, reception_complete, no_response);
    n_txn++;
    do_txn(mk("after_abort", 0, 1, 5, F1, F1, 1, 0, 0, 0));

    // reset asserted during RECEIVE after 30 frame samples
    enable_stp = 1'b1; cmd_in = 1'b1;
    tick();
    repeat (3) tick();
    for (int b = 47; b >= 18; b--) begin
      cmd_in = f1v[b];
      tick();
    end
    reset = 1'b0; enable_stp = 1'b0;
    tick();
    chk("midreset.pad", pad_response, 0);
    chk("midreset.flags", {reception_complete, no_response, crc_error, frame_error}, 0);
    $display("txn %0d midreset pad=%h rc=%0d nr=%0d", n_txn, pad_response, reception_complete, no_response);
    n_txn++;
    reset = 1'b1;
    tick();
    last_pad = '0;
    do_txn(mk("after_reset", 0, 1, 5, F1, F1, 1, 0, 0, 0));

    // random frames checked against the reference model
    for (int t = 0; t < 16; t++) begin
      lng = 1'($urandom);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      fr  = build_frame(lng, rnd);
      L   = lng ? 136 : 48;
      sel = $urandom_range(0, 3);
      if (sel == 1) begin
        pos = lng ? $urandom_range(8, 127) : $urandom_range(8, 45);
        fr[pos] = ~fr[pos];
      end else if (sel == 2) begin
        fr[0] = 1'b0;
      end else if (sel == 3) begin
        fr[L-2] = 1'b1;
      end
      idle = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 8);
      v = mk($sformatf("rand%0d", t), lng, 1'($urandom), idle, fr, '0, 0, 0, 0, 0);
      if (idle >= TO) begin
        v.exp_pad = last_pad;
        v.exp_nr  = 1'b1;
      end else begin
        ce = (crc7_ref(fr, lng) != fr[7:1]);
        v.exp_pad = fr;
        v.exp_rc  = 1'b1;
        v.exp_ce  = v.chk & ce;
        v.exp_fe  = fr[L-2] | ~fr[0];
      end
      do_txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
